// File: rtl/controle_buffer_rolhas_pkg.sv
// Shared definitions for the cork plant: FSM state codes, default buffer sizing and a small helper.
// Reused by the plant controller and the display encoders.
package pkg_rolhas;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StXfer    = 2'b01,
        StLoad    = 2'b10,
        StInvalid = 2'b11
    } estado_e;

    localparam int unsigned MainDepthDef = 20;
    localparam int unsigned SecDepthDef  = 99;
    localparam int unsigned XferQtyDef   = 15;
    localparam int unsigned MinMainDef   = 5;

    function automatic int unsigned min3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

endpackage

// File: rtl/controle_buffer_rolhas_edge.sv
// Level-to-pulse converter: one-cycle pulse on a rising edge of a level input.
module controle_buffer_rolhas_edge (
    input  logic clk,
    input  logic clr,
    input  logic level,
    output logic pulse
);

    logic prev_q;

    // Resets to 1 so a level already high at reset release is not taken as an edge.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= level;
        end
    end

    assign pulse = level & ~prev_q;

endmodule

// File: rtl/controle_buffer_rolhas.sv
// Cork buffer controller: refills the main buffer from the reserve buffer and accepts operator
// loads into the reserve, while the sealer drains the main buffer.
module controle_buffer_rolhas
    import pkg_rolhas::*;
#(
    parameter int unsigned MAIN_DEPTH = MainDepthDef,
    parameter int unsigned SEC_DEPTH  = SecDepthDef,
    parameter int unsigned XFER_QTY   = XferQtyDef,
    parameter int unsigned MIN_MAIN   = MinMainDef,
    localparam int unsigned MW = $clog2(MAIN_DEPTH + 1),
    localparam int unsigned SW = $clog2(SEC_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          enable,
    input  logic          seal,
    input  logic          op_load,
    input  logic [SW-1:0] op_qty,
    output logic [MW-1:0] main_count,
    output logic [SW-1:0] sec_count,
    output logic [1:0]    state,
    output logic          ro,
    output logic          op_reject,
    output logic          xfer_done
);

    estado_e       state_q, state_d;
    logic [MW-1:0] main_q, main_d;
    logic [SW-1:0] sec_q, sec_d;
    logic [SW-1:0] n_q, n_d;
    logic          load_edge;
    logic          xfer_cond, load_ok, inc, dec;

    controle_buffer_rolhas_edge u_edge (
        .clk   (clk),
        .clr   (clr),
        .level (op_load),
        .pulse (load_edge)
    );

    assign xfer_cond = enable && (32'(main_q) <= MIN_MAIN) && (sec_q != '0);
    assign load_ok   = (op_qty != '0) && ((32'(sec_q) + 32'(op_qty)) <= SEC_DEPTH);
    assign dec       = seal && (main_q != '0);

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        sec_d     = sec_q;
        inc       = 1'b0;
        op_reject = 1'b0;
        xfer_done = 1'b0;
        case (state_q)
            StIdle: begin
                if (xfer_cond) begin
                    state_d   = StXfer;
                    n_d       = SW'(min3(XFER_QTY, 32'(sec_q), MAIN_DEPTH - 32'(main_q)));
                    op_reject = load_edge;
                end else if (load_edge) begin
                    if (enable && load_ok) begin
                        state_d = StLoad;
                        n_d     = op_qty;
                    end else begin
                        op_reject = 1'b1;
                    end
                end
            end
            StXfer: begin
                inc       = 1'b1;
                sec_d     = sec_q - 1'b1;
                n_d       = n_q - 1'b1;
                op_reject = load_edge;
                if (n_q <= SW'(1)) begin
                    xfer_done = 1'b1;
                    state_d   = StIdle;
                end
            end
            StLoad: begin
                sec_d     = sec_q + 1'b1;
                n_d       = n_q - 1'b1;
                op_reject = load_edge;
                if (n_q <= SW'(1)) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d   = StIdle;
                n_d       = '0;
                op_reject = load_edge;
            end
        endcase

        // A seal coinciding with a transfer increment leaves main unchanged.
        case ({inc, dec})
            2'b10:   main_d = main_q + 1'b1;
            2'b01:   main_d = main_q - 1'b1;
            default: main_d = main_q;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= StIdle;
            main_q  <= '0;
            sec_q   <= '0;
            n_q     <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            sec_q   <= sec_d;
            n_q     <= n_d;
        end
    end

    assign main_count = main_q;
    assign sec_count  = sec_q;
    assign state      = state_q;
    assign ro         = (main_q == '0);

endmodule

// File: tb/tb_controle_buffer_rolhas.sv
// Directed bench for controle_buffer_rolhas with default parameters.
module tb_controle_buffer_rolhas;

    localparam int MW = 5;
    localparam int SW = 7;

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic          enable = 1'b0;
    logic          seal = 1'b0;
    logic          op_load = 1'b0;
    logic [SW-1:0] op_qty = '0;
    logic [MW-1:0] main_count;
    logic [SW-1:0] sec_count;
    logic [1:0]    state;
    logic          ro;
    logic          op_reject;
    logic          xfer_done;

    int compared = 0;
    int mismatched = 0;

    controle_buffer_rolhas dut (
        .clk        (clk),
        .clr        (clr),
        .enable     (enable),
        .seal       (seal),
        .op_load    (op_load),
        .op_qty     (op_qty),
        .main_count (main_count),
        .sec_count  (sec_count),
        .state      (state),
        .ro         (ro),
        .op_reject  (op_reject),
        .xfer_done  (xfer_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Starts an operator load (enable must be high) and lets it finish with enable dropped.
    task automatic load_hold(input int qty);
        op_qty  = SW'(qty);
        op_load = 1'b1;
        step();
        op_load = 1'b0;
        enable  = 1'b0;
        repeat (qty) step();
    endtask

    task automatic run_xfer(input int n);
        enable = 1'b1;
        step();
        enable = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        int cnt;
        logic held;

        // Reset values, with op_load held high through release.
        op_load = 1'b1;
        op_qty  = 7'd5;
        enable  = 1'b1;
        step();
        step();
        chk("rst_main", main_count, 0);
        chk("rst_sec", sec_count, 0);
        chk("rst_state", state, 0);
        chk("rst_ro", ro, 1);
        chk("rst_reject", op_reject, 0);
        chk("rst_done", xfer_done, 0);
        clr = 1'b1;
        repeat (3) step();
        chk("held_load_state", state, 0);
        chk("held_load_sec", sec_count, 0);
        seal = 1'b1;
        step();
        chk("seal_empty_main", main_count, 0);
        chk("seal_empty_ro", ro, 1);
        seal    = 1'b0;
        op_load = 1'b0;
        step();

        // Load 40 into reserve, then a full 15-cork transfer.
        load_hold(40);
        chk("l40_sec", sec_count, 40);
        chk("l40_main", main_count, 0);
        chk("l40_state", state, 0);
        enable = 1'b1;
        step();
        pulses = 0;
        held   = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (state !== 2'd1) held = 1'b0;
            if (xfer_done === 1'b1) pulses++;
            if (i == 14) chk("x15_done_last", xfer_done, 1);
            step();
        end
        chk("x15_in_xfer", held, 1);
        chk("x15_pulses", pulses, 1);
        chk("x15_main", main_count, 15);
        chk("x15_sec", sec_count, 25);
        chk("x15_state", state, 0);

        // Overfull load is refused, then an exact fill to capacity.
        enable = 1'b1;
        load_hold(70);
        chk("l70_sec", sec_count, 95);
        enable  = 1'b1;
        op_qty  = 7'd10;
        op_load = 1'b1;
        #1;
        chk("ovf_reject", op_reject, 1);
        step();
        chk("ovf_state", state, 0);
        chk("ovf_sec", sec_count, 95);
        chk("ovf_reject_once", op_reject, 0);
        op_load = 1'b0;
        step();
        op_qty  = 7'd4;
        op_load = 1'b1;
        step();
        op_load = 1'b0;
        cnt = 0;
        while (state === 2'd2 && cnt < 20) begin
            cnt++;
            step();
        end
        chk("l4_cycles", cnt, 4);
        chk("l4_sec", sec_count, 99);

        // Load edge coincident with transfer trigger; load edge during transfer.
        enable = 1'b0;
        seal   = 1'b1;
        repeat (10) step();
        seal = 1'b0;
        chk("drain_main", main_count, 5);
        enable  = 1'b1;
        op_qty  = 7'd1;
        op_load = 1'b1;
        #1;
        chk("prio_reject", op_reject, 1);
        step();
        chk("prio_state", state, 1);
        chk("prio_reject_once", op_reject, 0);
        op_load = 1'b0;
        step();
        op_load = 1'b1;
        #1;
        chk("busy_reject", op_reject, 1);
        op_load = 1'b0;
        cnt = 0;
        while (state === 2'd1 && cnt < 40) begin
            cnt++;
            step();
        end
        chk("fill_state", state, 0);
        chk("fill_main", main_count, 20);
        chk("fill_sec", sec_count, 84);
        chk("fill_ro", ro, 0);

        // Reset in the middle of a transfer.
        enable = 1'b0;
        seal   = 1'b1;
        repeat (15) step();
        seal   = 1'b0;
        enable = 1'b1;
        step();
        chk("pre_abort_state", state, 1);
        repeat (6) step();
        clr = 1'b0;
        #1;
        chk("abort_state", state, 0);
        chk("abort_main", main_count, 0);
        chk("abort_sec", sec_count, 0);
        chk("abort_done", xfer_done, 0);
        step();
        chk("abort_done_hold", xfer_done, 0);
        seal = 1'b1;
        step();
        clr = 1'b1;
        step();
        chk("abort_seal_main", main_count, 0);
        chk("abort_seal_ro", ro, 1);
        seal = 1'b0;
        step();

        // Partial transfer limited by reserve contents.
        enable = 1'b1;
        load_hold(5);
        run_xfer(5);
        chk("m5_main", main_count, 5);
        chk("m5_sec", sec_count, 0);
        enable = 1'b1;
        load_hold(3);
        chk("s3_sec", sec_count, 3);
        enable = 1'b1;
        step();
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            if (xfer_done === 1'b1) pulses++;
            step();
        end
        chk("x3_pulses", pulses, 1);
        chk("x3_main", main_count, 8);
        chk("x3_sec", sec_count, 0);
        seal = 1'b1;
        repeat (3) step();
        seal = 1'b0;
        repeat (3) step();
        chk("empty_sec_state", state, 0);
        chk("empty_sec_main", main_count, 5);

        // Seal on every transfer cycle keeps main constant.
        seal = 1'b1;
        repeat (3) step();
        seal = 1'b0;
        chk("m2_main", main_count, 2);
        load_hold(20);
        chk("s20_sec", sec_count, 20);
        enable = 1'b1;
        step();
        enable = 1'b0;
        seal   = 1'b1;
        held   = 1'b1;
        repeat (15) begin
            step();
            if (main_count !== 5'd2) held = 1'b0;
        end
        seal = 1'b0;
        chk("sealx_main_held", held, 1);
        chk("sealx_sec", sec_count, 5);
        chk("sealx_state", state, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
